// File: rtl/loa_error_monitor_if.sv
// Sample/statistics bus of the LOA error monitor.
// master drives samples and stats_ready; slave is the monitor.
interface loa_error_monitor_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int SUM_W = 48
);
  logic             start_i;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic [WIDTH:0]   approx_i;
  logic             valid_i;
  logic             ready_o;
  logic             busy_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [WIDTH:0]   max_ed_o;
  logic [SUM_W-1:0] sum_ed_o;
  logic             stats_valid_o;
  logic             stats_ready_i;

  modport master (
    output start_i, add1_i, add2_i,
    output approx_i, valid_i,
    output stats_ready_i,
    input  ready_o, busy_o,
    input  err_cnt_o, max_ed_o,
    input  sum_ed_o, stats_valid_o
  );

  modport slave (
    input  start_i, add1_i, add2_i,
    input  approx_i, valid_i,
    input  stats_ready_i,
    output ready_o, busy_o,
    output err_cnt_o, max_ed_o,
    output sum_ed_o, stats_valid_o
  );
endinterface

// File: rtl/loa_error_monitor.sv
// Error-distance monitor behind the LOA adder: 2-stage ED pipe,
// windowed err count / max / saturating sum, reported via valid/ready.
module loa_error_monitor #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16,
  parameter int SUM_W  = 48
) (
  input logic clk_i,
  input logic rst_i,
  loa_error_monitor_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ACCUM, DRAIN, REPORT
  } state_e;

  localparam logic [CNT_W-1:0] WIN =
    CNT_W'(WINDOW);
  localparam int AW =
    ((SUM_W > WIDTH + 1) ? SUM_W : WIDTH + 1) + 1;
  localparam logic [AW-1:0] SAT =
    (AW'(1) << SUM_W) - AW'(1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_v_q, s1_v_d;
  logic [WIDTH:0]   s1_ex_q, s1_ex_d;
  logic [WIDTH:0]   s1_ap_q, s1_ap_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH:0]   s2_ed_q, s2_ed_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [WIDTH:0]   max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  logic ready, busy, stats_valid;
  logic accept, last, clr;
  logic [AW-1:0] sum_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.start_i) state_d = ACCUM;
      ACCUM:  if (last) state_d = DRAIN;
      // Empty pipe means the last ED has been accumulated.
      DRAIN:  if (!s1_v_q && !s2_v_q) state_d = REPORT;
      REPORT: if (bus.stats_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    busy        = 1'b0;
    stats_valid = 1'b0;
    unique case (state_q)
      IDLE: ;
      ACCUM: begin
        busy  = 1'b1;
        ready = (cnt_q < WIN);
      end
      DRAIN: busy = 1'b1;
      REPORT: begin
        busy        = 1'b1;
        stats_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = ready && bus.valid_i;
  assign last   = accept &&
                  (cnt_q == WIN - CNT_W'(1));
  assign clr    = (state_q == IDLE) && bus.start_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)         cnt_d = '0;
    else if (accept) cnt_d = cnt_q + CNT_W'(1);

    s1_v_d  = accept;
    s1_ex_d = {1'b0, bus.add1_i} +
              {1'b0, bus.add2_i};
    s1_ap_d = bus.approx_i;

    s2_v_d  = s1_v_q;
    s2_ed_d = (s1_ex_q >= s1_ap_q) ?
              s1_ex_q - s1_ap_q :
              s1_ap_q - s1_ex_q;

    // Widened add so the carry shows saturation even when
    // SUM_W is narrower than the ED itself.
    sum_ext = AW'(sum_q) + AW'(s2_ed_q);

    err_d = err_q;
    max_d = max_q;
    sum_d = sum_q;
    if (clr) begin
      err_d = '0;
      max_d = '0;
      sum_d = '0;
    end else if (s2_v_q) begin
      if (s2_ed_q != '0)
        err_d = err_q + CNT_W'(1);
      if (s2_ed_q > max_q)
        max_d = s2_ed_q;
      sum_d = (sum_ext > SAT) ?
              SUM_W'(SAT) : SUM_W'(sum_ext);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_ex_q <= '0;
      s1_ap_q <= '0;
      s2_v_q  <= 1'b0;
      s2_ed_q <= '0;
      err_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      s1_v_q  <= s1_v_d;
      s1_ex_q <= s1_ex_d;
      s1_ap_q <= s1_ap_d;
      s2_v_q  <= s2_v_d;
      s2_ed_q <= s2_ed_d;
      err_q   <= err_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.busy_o        = busy;
  assign bus.stats_valid_o = stats_valid;
  assign bus.err_cnt_o     = err_q;
  assign bus.max_ed_o      = max_q;
  assign bus.sum_ed_o      = sum_q;
endmodule

// File: tb/tb_loa_error_monitor.sv
// Directed bench for loa_error_monitor (WINDOW=4):
// one DUT with SUM_W=48, one with SUM_W=8 for saturation.
module tb_loa_error_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  loa_error_monitor_if #(
    .WIDTH(32), .CNT_W(16), .SUM_W(48)
  ) ifa ();
  loa_error_monitor_if #(
    .WIDTH(32), .CNT_W(16), .SUM_W(8)
  ) ifb ();

  assign ifb.start_i       = ifa.start_i;
  assign ifb.add1_i        = ifa.add1_i;
  assign ifb.add2_i        = ifa.add2_i;
  assign ifb.approx_i      = ifa.approx_i;
  assign ifb.valid_i       = ifa.valid_i;
  assign ifb.stats_ready_i = ifa.stats_ready_i;

  loa_error_monitor #(
    .WIDTH(32), .WINDOW(4),
    .CNT_W(16), .SUM_W(48)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa)
  );

  loa_error_monitor #(
    .WIDTH(32), .WINDOW(4),
    .CNT_W(16), .SUM_W(8)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [32:0] x);
    ifa.add1_i   = a;
    ifa.add2_i   = b;
    ifa.approx_i = x;
    ifa.valid_i  = 1'b1;
    tick();
  endtask

  task automatic wait_sv(input string tag);
    int n;
    n = 0;
    while (ifa.stats_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(ifa.stats_valid_o), 64'd1);
  endtask

  task automatic do_start();
    ifa.start_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
  endtask

  task automatic chk_stats(input string tag,
                           input logic [63:0] e,
                           input logic [63:0] m,
                           input logic [63:0] s);
    chk({tag, "_err"}, 64'(ifa.err_cnt_o), e);
    chk({tag, "_max"}, 64'(ifa.max_ed_o), m);
    chk({tag, "_sum"}, 64'(ifa.sum_ed_o), s);
  endtask

  task automatic handshake();
    ifa.stats_ready_i = 1'b1;
    tick();
    ifa.stats_ready_i = 1'b0;
  endtask

  initial begin
    int acc, n;
    logic v;
    logic [31:0] a;
    logic [32:0] ex, ap, kk;

    ifa.start_i       = 1'b0;
    ifa.add1_i        = '0;
    ifa.add2_i        = '0;
    ifa.approx_i      = '0;
    ifa.valid_i       = 1'b0;
    ifa.stats_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ready", 64'(ifa.ready_o), 0);
    chk("rst_busy", 64'(ifa.busy_o), 0);
    chk("rst_sv", 64'(ifa.stats_valid_o), 0);
    chk_stats("rst", 0, 0, 0);
    chk("rst_b_sum", 64'(ifb.sum_ed_o), 0);

    // Test 1: three zero-ED samples then ED=1
    do_start();
    chk("t1_ready", 64'(ifa.ready_o), 1);
    chk("t1_busy", 64'(ifa.busy_o), 1);
    drive(32'h12340000, 32'h00010000, 33'h012350000);
    drive(32'h12340000, 32'h00010000, 33'h012350000);
    drive(32'h12340000, 32'h00010000, 33'h012350000);
    drive(32'h000000FF, 32'h00000001, 33'h0000000FF);
    ifa.valid_i = 1'b0;
    chk("t1_rdy_low", 64'(ifa.ready_o), 0);
    chk("t1_sv_c1", 64'(ifa.stats_valid_o), 0);
    tick();
    chk("t1_sv_c2", 64'(ifa.stats_valid_o), 0);
    tick();
    chk("t1_sv_c3", 64'(ifa.stats_valid_o), 0);
    tick();
    chk("t1_sv_c4", 64'(ifa.stats_valid_o), 1);
    chk_stats("t1", 1, 1, 1);
    chk("t1_b_sum", 64'(ifb.sum_ed_o), 1);
    handshake();
    chk("t1_idle_sv", 64'(ifa.stats_valid_o), 0);
    chk("t1_idle_busy", 64'(ifa.busy_o), 0);
    chk("t1_retain", 64'(ifa.err_cnt_o), 1);

    // Test 2/4: four ED=0x80 samples; B saturates
    do_start();
    chk("t2_clr_err", 64'(ifa.err_cnt_o), 0);
    chk("t2_clr_max", 64'(ifa.max_ed_o), 0);
    for (int i = 0; i < 4; i++)
      drive(32'h80, 32'h80, 33'h180);
    ifa.valid_i = 1'b0;
    wait_sv("t2_sv");
    chk_stats("t2", 4, 64'h80, 64'h200);
    chk("t4_b_sum", 64'(ifb.sum_ed_o), 64'hFF);
    chk("t4_b_max", 64'(ifb.max_ed_o), 64'h80);
    chk("t4_b_err", 64'(ifb.err_cnt_o), 4);

    // Test 6b: start in REPORT, also with handshake
    ifa.start_i = 1'b1;
    tick();
    chk("t6_rep_sv", 64'(ifa.stats_valid_o), 1);
    chk("t6_rep_err", 64'(ifa.err_cnt_o), 4);
    ifa.stats_ready_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
    ifa.stats_ready_i = 1'b0;
    chk("t6_hs_busy", 64'(ifa.busy_o), 0);
    chk("t6_hs_sv", 64'(ifa.stats_valid_o), 0);
    tick();
    chk("t6_idle_busy", 64'(ifa.busy_o), 0);
    chk("t6_idle_err", 64'(ifa.err_cnt_o), 4);

    // Test 3: random gaps, sample k has ED=k
    do_start();
    acc = 0;
    n = 0;
    while (ifa.stats_valid_o !== 1'b1 && n < 60) begin
      v = (n > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      kk = 33'(acc);
      a = 32'h100 * 32'(acc) + 32'd5;
      ex = {1'b0, a} + 33'h10;
      ap = kk[0] ? ex + kk : ex - kk;
      ifa.add1_i = a;
      ifa.add2_i = 32'h10;
      ifa.approx_i = ap;
      ifa.valid_i = v;
      chk("t3_ready", 64'(ifa.ready_o),
          (acc < 4) ? 64'd1 : 64'd0);
      if (v && acc < 4) acc++;
      tick();
      n++;
    end
    ifa.valid_i = 1'b0;
    chk("t3_sv", 64'(ifa.stats_valid_o), 1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_sv", 64'(ifa.stats_valid_o), 1);
      chk("t3_hold_rdy", 64'(ifa.ready_o), 0);
      chk_stats("t3_hold", 3, 3, 6);
      tick();
    end
    handshake();
    chk("t3_idle_busy", 64'(ifa.busy_o), 0);
    chk("t3_idle_sv", 64'(ifa.stats_valid_o), 0);
    chk("t3_idle_rdy", 64'(ifa.ready_o), 0);

    // Test 5: reset mid-ACCUM after 2 accepts
    do_start();
    drive(32'h80, 32'h80, 33'h180);
    drive(32'h80, 32'h80, 33'h180);
    ifa.valid_i = 1'b0;
    rst = 1'b1;
    ifa.start_i = 1'b1;
    tick();
    rst = 1'b0;
    ifa.start_i = 1'b0;
    chk("t5_ready", 64'(ifa.ready_o), 0);
    chk("t5_busy", 64'(ifa.busy_o), 0);
    chk("t5_sv", 64'(ifa.stats_valid_o), 0);
    chk_stats("t5_rst", 0, 0, 0);
    tick();
    tick();
    chk_stats("t5_flush", 0, 0, 0);
    chk("t5_b_sum", 64'(ifb.sum_ed_o), 0);

    // Test 6a: new window, start during ACCUM
    do_start();
    drive(32'h000000FF, 32'h00000001, 33'h0000000FF);
    drive(32'h12340000, 32'h00010000, 33'h012350000);
    drive(32'h12340000, 32'h00010000, 33'h012350000);
    chk("t6_acc_err", 64'(ifa.err_cnt_o), 1);
    ifa.start_i = 1'b1;
    drive(32'h12340000, 32'h00010000, 33'h012350000);
    ifa.start_i = 1'b0;
    ifa.valid_i = 1'b0;
    chk("t6_drain_rdy", 64'(ifa.ready_o), 0);
    chk("t6_drain_busy", 64'(ifa.busy_o), 1);
    wait_sv("t5_sv2");
    chk_stats("t5_new", 1, 1, 1);
    chk("t5_b_new_sum", 64'(ifb.sum_ed_o), 1);
    handshake();
    chk("t5_end_busy", 64'(ifa.busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
